// File: rtl/pc_attack_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pc_attack_engine
//
// Plays the PC's move while the game FSM sits in PC_TURN. The engine draws
// pseudo-random cells from an 8-bit LFSR until it finds one that has not been
// attacked yet. After MAX_TRIES rejected draws it falls back to a linear scan.
// It waits THINK_CYCLES so the move is visible on screen, then fires. The shot
// is resolved against the player's ship map, and the attack/hit maps read by
// the VGA renderer are updated.
//
// Ports:
//   clk                system clock, all state changes on the rising edge
//   rst                asynchronous active-low reset
//   setup_State        game in SETUP: clear maps, load ship count, arm engine
//   pc_turn_State      game in PC_TURN: one move per visit
//   player_ship_map    1 = cell holds a player ship part (row-major)
//   pc_has_move        one-cycle pulse, move finished
//   player_ships_zero  armed and no unhit player ship cells left
//   pc_attacked_map    1 = PC has attacked this cell
//   pc_hit_map         1 = attacked cell was a ship
//   last_target        index of the most recently fired cell
//   last_hit           most recent shot was a hit
//   busy               engine not idle
// -----------------------------------------------------------------------------
module pc_attack_engine #(
    parameter int         BOARD_N      = 5,
    parameter int         CELL_W       = 5,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         MAX_TRIES    = 16,
    parameter int         THINK_CYCLES = 25_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         setup_State,
    input  logic                         pc_turn_State,
    input  logic [BOARD_N*BOARD_N-1:0]   player_ship_map,
    output logic                         pc_has_move,
    output logic                         player_ships_zero,
    output logic [BOARD_N*BOARD_N-1:0]   pc_attacked_map,
    output logic [BOARD_N*BOARD_N-1:0]   pc_hit_map,
    output logic [CELL_W-1:0]            last_target,
    output logic                         last_hit,
    output logic                         busy
);

    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    // The cell count is compared one bit wider so that a board exactly filling
    // the index space (2**CELL_W == CELLS) does not wrap to zero.
    localparam logic [CELL_W:0]    CELLS_EXT  = (CELL_W+1)'(CELLS);
    localparam logic [CELL_W-1:0]  LAST_IDX   = CELL_W'(CELLS - 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);
    // With THINK_CYCLES = 0 the terminal count is 0, so THINK lasts exactly
    // one cycle.
    localparam logic [31:0] THINK_LAST =
        (THINK_CYCLES == 0) ? 32'd0 : 32'(THINK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SCAN,
        THINK,
        FIRE,
        DONE,
        WAIT
    } state_t;

    state_t              state_reg,     state_next;
    logic [7:0]          lfsr_reg,      lfsr_next;
    logic [CELL_W:0]     remaining_reg, remaining_next;
    logic                armed_reg,     armed_next;
    logic [TRIES_W-1:0]  tries_reg,     tries_next;
    logic [31:0]         think_reg,     think_next;
    logic [CELL_W-1:0]   scan_reg,      scan_next;
    logic [CELL_W-1:0]   target_reg,    target_next;
    logic [CELLS-1:0]    attacked_reg,  attacked_next;
    logic [CELLS-1:0]    hit_reg,       hit_next;
    logic [CELL_W-1:0]   last_target_reg, last_target_next;
    logic                last_hit_reg,    last_hit_next;

    // Ship-part count of the player's map, built as a prefix-sum chain.
    logic [CELL_W:0] pop_acc [0:CELLS];

    assign pop_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_popcount
            assign pop_acc[gi+1] = pop_acc[gi] + {{CELL_W{1'b0}}, player_ship_map[gi]};
        end
    endgenerate

    // Fibonacci LFSR, taps 8,6,5,4: shift left, feed back into bit 0.
    logic [7:0]        lfsr_step;
    logic [CELL_W-1:0] cand;
    logic              cand_free;

    assign lfsr_step = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign cand      = lfsr_step[CELL_W-1:0];
    // The range test short-circuits the map lookup for out-of-board indices.
    assign cand_free = ({1'b0, cand} < CELLS_EXT) && !attacked_reg[cand];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            lfsr_reg        <= LFSR_SEED;
            remaining_reg   <= '0;
            armed_reg       <= 1'b0;
            tries_reg       <= '0;
            think_reg       <= '0;
            scan_reg        <= '0;
            target_reg      <= '0;
            attacked_reg    <= '0;
            hit_reg         <= '0;
            last_target_reg <= '0;
            last_hit_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lfsr_reg        <= lfsr_next;
            remaining_reg   <= remaining_next;
            armed_reg       <= armed_next;
            tries_reg       <= tries_next;
            think_reg       <= think_next;
            scan_reg        <= scan_next;
            target_reg      <= target_next;
            attacked_reg    <= attacked_next;
            hit_reg         <= hit_next;
            last_target_reg <= last_target_next;
            last_hit_reg    <= last_hit_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        lfsr_next        = lfsr_reg;
        remaining_next   = remaining_reg;
        armed_next       = armed_reg;
        tries_next       = tries_reg;
        think_next       = think_reg;
        scan_next        = scan_reg;
        target_next      = target_reg;
        attacked_next    = attacked_reg;
        hit_next         = hit_reg;
        last_target_next = last_target_reg;
        last_hit_next    = last_hit_reg;

        if (setup_State) begin
            attacked_next  = '0;
            hit_next       = '0;
            remaining_next = pop_acc[CELLS];
            armed_next     = 1'b1;
            state_next     = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (pc_turn_State && armed_reg) begin
                        state_next = PICK;
                        tries_next = '0;
                    end
                end

                PICK: begin
                    if (!pc_turn_State) begin
                        state_next = IDLE;
                    end else begin
                        lfsr_next = lfsr_step;
                        if (cand_free) begin
                            target_next = cand;
                            think_next  = '0;
                            state_next  = THINK;
                        end else if (tries_reg == TRIES_LAST) begin
                            scan_next  = '0;
                            state_next = SCAN;
                        end else begin
                            tries_next = tries_reg + 1'b1;
                        end
                    end
                end

                SCAN: begin
                    if (!pc_turn_State) begin
                        state_next = IDLE;
                    end else if (!attacked_reg[scan_reg]) begin
                        target_next = scan_reg;
                        think_next  = '0;
                        state_next  = THINK;
                    end else if (scan_reg == LAST_IDX) begin
                        // Board is full: finish the turn without firing.
                        state_next = DONE;
                    end else begin
                        scan_next = scan_reg + 1'b1;
                    end
                end

                THINK: begin
                    if (!pc_turn_State) begin
                        state_next = IDLE;
                    end else if (think_reg == THINK_LAST) begin
                        state_next = FIRE;
                    end else begin
                        think_next = think_reg + 32'd1;
                    end
                end

                FIRE: begin
                    attacked_next[target_reg] = 1'b1;
                    last_target_next          = target_reg;
                    last_hit_next             = player_ship_map[target_reg];
                    if (player_ship_map[target_reg]) begin
                        hit_next[target_reg] = 1'b1;
                        if (remaining_reg != '0) begin
                            remaining_next = remaining_reg - 1'b1;
                        end
                    end
                    state_next = DONE;
                end

                DONE: begin
                    state_next = WAIT;
                end

                WAIT: begin
                    // Hold until the game leaves PC_TURN so a long turn
                    // level never produces a second move.
                    if (!pc_turn_State) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign pc_has_move       = (state_reg == DONE);
    assign busy              = (state_reg != IDLE);
    assign player_ships_zero = armed_reg && (remaining_reg == '0);
    assign pc_attacked_map   = attacked_reg;
    assign pc_hit_map        = hit_reg;
    assign last_target       = last_target_reg;
    assign last_hit          = last_hit_reg;

endmodule
